// File: rtl/scan_pkg.sv
// Shared types and constants for the scan index sequencer.
//   state_e : sequencer FSM states
//   MODE_*  : encodings of the 2-bit mode input
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

endpackage

// File: rtl/scan_index_sequencer_next_chan_finder.sv
// Combinational search for the next eligible channel.
// A channel is eligible when its index is below N_CHAN and its skip bit is 0.
// Ports:
//   cur_idx       : index the search starts from (excluded from the forward search)
//   dir_down      : 0 = search upward, 1 = search downward
//   pingpong      : at an end, turn around instead of wrapping to the far end
//   skip_mask     : bit i = 1 skips channel i
//   next_idx      : selected channel
//   wrapped       : the search ran off the end (wrap-around or turnaround)
//   reverse       : ping-pong turnaround happened, direction must flip
//   none_eligible : no channel is eligible at all
// Starting the search from the far end (N_CHAN-1 upward, or 0 downward) makes
// the wrap path return the lowest/highest eligible channel, which is how the
// first channel of a scan is found.
module next_chan_finder
  import scan_pkg::*;
#(
  parameter int IDX_W  = 3,
  parameter int N_CHAN = 8
) (
  input  logic [IDX_W-1:0]      cur_idx,
  input  logic                  dir_down,
  input  logic                  pingpong,
  input  logic [2**IDX_W-1:0]   skip_mask,
  output logic [IDX_W-1:0]      next_idx,
  output logic                  wrapped,
  output logic                  reverse,
  output logic                  none_eligible
);

  localparam int NUM = 2**IDX_W;

  logic [NUM-1:0]   elig;
  logic             fwd_found;
  logic             back_found;
  logic [IDX_W-1:0] fwd_idx;
  logic [IDX_W-1:0] back_idx;
  logic [IDX_W-1:0] end_idx;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM; i++) begin
      elig[i] = (i < N_CHAN) && !skip_mask[i];
    end
  end

  // fwd_*  : nearest eligible channel strictly ahead in the search direction
  // back_* : nearest eligible channel strictly behind (ping-pong turnaround)
  // end_idx: first eligible channel seen from the far end (wrap target)
  always_comb begin
    fwd_found  = 1'b0;
    back_found = 1'b0;
    fwd_idx    = '0;
    back_idx   = '0;
    end_idx    = '0;
    if (!dir_down) begin
      // Descending loop: the last hit is the lowest matching index.
      for (int i = NUM - 1; i >= 0; i--) begin
        if (elig[i] && (i > int'(cur_idx))) begin
          fwd_found = 1'b1;
          fwd_idx   = IDX_W'(i);
        end
        if (elig[i]) begin
          end_idx = IDX_W'(i);
        end
      end
      // Ascending loop: the last hit is the highest index below cur_idx.
      for (int i = 0; i < NUM; i++) begin
        if (elig[i] && (i < int'(cur_idx))) begin
          back_found = 1'b1;
          back_idx   = IDX_W'(i);
        end
      end
    end else begin
      for (int i = 0; i < NUM; i++) begin
        if (elig[i] && (i < int'(cur_idx))) begin
          fwd_found = 1'b1;
          fwd_idx   = IDX_W'(i);
        end
        if (elig[i]) begin
          end_idx = IDX_W'(i);
        end
      end
      for (int i = NUM - 1; i >= 0; i--) begin
        if (elig[i] && (i > int'(cur_idx))) begin
          back_found = 1'b1;
          back_idx   = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    none_eligible = ~|elig;
    next_idx      = fwd_idx;
    wrapped       = 1'b0;
    reverse       = 1'b0;
    if (!fwd_found) begin
      wrapped = 1'b1;
      if (pingpong) begin
        reverse  = 1'b1;
        // Nothing behind either means cur_idx is the single eligible channel.
        next_idx = back_found ? back_idx : end_idx;
      end else begin
        next_idx = end_idx;
      end
    end
  end

endmodule

// File: rtl/scan_index_sequencer.sv
// Scan index sequencer: drives idx/en of a one-hot channel decoder.
// Sweeps eligible channels (up, down, ping-pong or hold), holding en high for
// DWELL cycles per channel with BLANK low cycles between channels.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : begins a scan from IDLE (ignored elsewhere)
//   stop      : ends the scan at the next channel boundary
//   mode      : 00 up, 01 down, 10 ping-pong, 11 hold
//   skip_mask : bit i = 1 skips channel i
//   idx, en   : registered decoder index and enable
//   wrap      : one-cycle pulse when a sweep completes
//   busy      : high whenever the sequencer is not IDLE
module scan_index_sequencer
  import scan_pkg::*;
#(
  parameter int IDX_W  = 3,
  parameter int N_CHAN = 8,
  parameter int DWELL  = 4,
  parameter int BLANK  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [1:0]          mode,
  input  logic [2**IDX_W-1:0] skip_mask,
  output logic [IDX_W-1:0]    idx,
  output logic                en,
  output logic                wrap,
  output logic                busy
);

  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK > 0) ? CNT_W'(BLANK - 1) : '0;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic             en_q,    en_d;
  logic             wrap_q,  wrap_d;
  logic             busy_q,  busy_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             dir_q,   dir_d;   // ping-pong direction, 1 = down
  logic             stop_q,  stop_d;  // pending stop
  logic             hold_q,  hold_d;  // parked in hold mode

  logic             adv;
  logic             stop_pend;

  logic [IDX_W-1:0] nxt_idx;
  logic             nxt_wrap;
  logic             nxt_rev;
  logic             nxt_none;

  logic [IDX_W-1:0] first_cur;
  logic [IDX_W-1:0] first_idx;
  logic             first_none;
  logic             start_unused_wrap;
  logic             start_unused_rev;
  logic             start_unused;

  // Advance search from the current channel.
  next_chan_finder #(.IDX_W(IDX_W), .N_CHAN(N_CHAN)) u_next (
    .cur_idx       (idx_q),
    .dir_down      ((mode == MODE_PP) ? dir_q : (mode == MODE_DOWN)),
    .pingpong      (mode == MODE_PP),
    .skip_mask     (skip_mask),
    .next_idx      (nxt_idx),
    .wrapped       (nxt_wrap),
    .reverse       (nxt_rev),
    .none_eligible (nxt_none)
  );

  // First channel at start: search from the far end so the wrap path yields
  // the lowest (or, for down, highest) eligible channel.
  assign first_cur = (mode == MODE_DOWN) ? '0 : IDX_W'(N_CHAN - 1);

  next_chan_finder #(.IDX_W(IDX_W), .N_CHAN(N_CHAN)) u_first (
    .cur_idx       (first_cur),
    .dir_down      (mode == MODE_DOWN),
    .pingpong      (1'b0),
    .skip_mask     (skip_mask),
    .next_idx      (first_idx),
    .wrapped       (start_unused_wrap),
    .reverse       (start_unused_rev),
    .none_eligible (first_none)
  );

  assign start_unused = start_unused_wrap ^ start_unused_rev;

  assign stop_pend = stop_q | stop;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    en_d    = en_q;
    wrap_d  = 1'b0;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    stop_d  = stop_q;
    hold_d  = hold_q;
    adv     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stop_d = 1'b0;
        hold_d = 1'b0;
        // stop beats start; a fully masked array cannot start.
        if (start && !stop && !first_none) begin
          state_d = ST_SCAN;
          en_d    = 1'b1;
          idx_d   = first_idx;
          cnt_d   = '0;
          dir_d   = 1'b0;
        end
      end
      ST_SCAN: begin
        stop_d = stop_pend;
        // In hold every cycle is a boundary so stop/mode act immediately.
        if (hold_q) begin
          adv = 1'b1;
        end else if (cnt_q == DWELL_LAST) begin
          if (BLANK == 0) begin
            adv = 1'b1;
          end else begin
            state_d = ST_BLANK;
            en_d    = 1'b0;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BLANK: begin
        stop_d = stop_pend;
        if (cnt_q == BLANK_LAST) begin
          adv = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
      end
    endcase

    // Channel boundary: mode, mask and pending stop are only sampled here.
    if (adv) begin
      cnt_d = '0;
      if (stop_pend || nxt_none) begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
        stop_d  = 1'b0;
        hold_d  = 1'b0;
      end else if (mode == MODE_HOLD) begin
        state_d = ST_SCAN;
        en_d    = 1'b1;
        hold_d  = 1'b1;
      end else if (hold_q) begin
        // Leaving hold: full dwell on the held channel before moving on.
        state_d = ST_SCAN;
        en_d    = 1'b1;
        hold_d  = 1'b0;
      end else begin
        state_d = ST_SCAN;
        en_d    = 1'b1;
        idx_d   = nxt_idx;
        wrap_d  = nxt_wrap;
        if (mode == MODE_PP) begin
          dir_d = nxt_rev ? ~dir_q : dir_q;
        end else begin
          dir_d = (mode == MODE_DOWN);
        end
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      en_q    <= 1'b0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      stop_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      stop_q  <= stop_d;
      hold_q  <= hold_d;
    end
  end

  assign idx  = idx_q;
  assign en   = en_q;
  assign wrap = wrap_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_scan_index_sequencer.sv
// Scoreboard bench for scan_index_sequencer (IDX_W=3, N_CHAN=8, DWELL=4, BLANK=1).
// Expected {idx,en,wrap,busy} per cycle is built from channel lists and
// compared one entry per clock, sampled 1 time unit after the rising edge.
module tb_scan_index_sequencer;

  localparam int IDX_W  = 3;
  localparam int N_CHAN = 8;
  localparam int DWELL  = 4;
  localparam int BLANK  = 1;

  localparam logic [1:0] M_UP   = 2'b00;
  localparam logic [1:0] M_DOWN = 2'b01;
  localparam logic [1:0] M_PP   = 2'b10;
  localparam logic [1:0] M_HOLD = 2'b11;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic [1:0]       mode;
  logic [7:0]       skip_mask;
  logic [IDX_W-1:0] idx;
  logic             en;
  logic             wrap;
  logic             busy;

  logic [5:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  scan_index_sequencer #(
    .IDX_W(IDX_W), .N_CHAN(N_CHAN), .DWELL(DWELL), .BLANK(BLANK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .skip_mask (skip_mask),
    .idx       (idx),
    .en        (en),
    .wrap      (wrap),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s @cyc %0d: got idx=%0d en=%0b wrap=%0b busy=%0b, expected idx=%0d en=%0b wrap=%0b busy=%0b",
               tag, cyc, got[5:3], got[2], got[1], got[0], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic push(input int ch, input logic e, input logic w, input logic b);
    logic [2:0] c;
    c = 3'(ch);
    exp_q.push_back({c, e, w, b});
  endtask

  // Full channel slot: DWELL enabled cycles then BLANK gap cycles.
  task automatic push_chan(input int ch, input logic w);
    for (int k = 0; k < DWELL; k++) push(ch, 1'b1, (k == 0) ? w : 1'b0, 1'b1);
    for (int k = 0; k < BLANK; k++) push(ch, 1'b0, 1'b0, 1'b1);
  endtask

  // First two dwell cycles of a channel.
  task automatic push_head(input int ch, input logic w);
    push(ch, 1'b1, w, 1'b1);
    push(ch, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic drain(input string tag, input int n);
    logic [5:0] e;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() == 0) begin
        check({tag, "_underrun"}, {idx, en, wrap, busy}, 6'h3f);
      end else begin
        e = exp_q.pop_front();
        check(tag, {idx, en, wrap, busy}, e);
      end
    end
  endtask

  task automatic drain_all(input string tag);
    drain(tag, exp_q.size());
  endtask

  // Pushed expectations begin with the cycle right after start is sampled.
  task automatic run_from_start(input string tag);
    start = 1'b1;
    drain(tag, 1);
    start = 1'b0;
    drain_all(tag);
  endtask

  // Called once the 2nd dwell cycle of ch has been observed: stop is high
  // for that cycle, en stays high two more cycles, one blank, then IDLE.
  task automatic stop_in_second(input string tag, input int ch);
    stop = 1'b1;
    push(ch, 1'b1, 1'b0, 1'b1);
    drain(tag, 1);
    stop = 1'b0;
    push(ch, 1'b1, 1'b0, 1'b1);
    push(ch, 1'b0, 1'b0, 1'b1);
    push(ch, 1'b0, 1'b0, 1'b0);
    push(ch, 1'b0, 1'b0, 1'b0);
    drain_all(tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = M_UP; skip_mask = 8'h00;
    #1;

    // Reset state
    push(0, 0, 0, 0); push(0, 0, 0, 0);
    drain("reset", 2);
    rst = 1'b0;
    push(0, 0, 0, 0); push(0, 0, 0, 0);
    drain("idle", 2);

    // Up sweep, two full periods, then stop in the 2nd dwell cycle of idx 3
    mode = M_UP;
    for (int lap = 0; lap < 2; lap++)
      for (int ch = 0; ch < N_CHAN; ch++) push_chan(ch, (lap > 0) && (ch == 0));
    push_chan(0, 1'b1); push_chan(1, 1'b0); push_chan(2, 1'b0); push_head(3, 1'b0);
    run_from_start("up");
    stop_in_second("up_stop", 3);

    // Restart resumes at 0; mask everything during dwell on idx 5
    for (int ch = 0; ch < 5; ch++) push_chan(ch, 1'b0);
    push(5, 1, 0, 1);
    run_from_start("restart");
    skip_mask = 8'hFF;
    push(5, 1, 0, 1); push(5, 1, 0, 1); push(5, 1, 0, 1);
    push(5, 0, 0, 1);
    push(5, 0, 0, 0); push(5, 0, 0, 0);
    drain_all("mask_mid");
    start = 1'b1;
    push(5, 0, 0, 0); push(5, 0, 0, 0); push(5, 0, 0, 0);
    drain_all("mask_all_start");
    start = 1'b0;

    // Down with channels 0 and 2 skipped
    mode = M_DOWN; skip_mask = 8'h05;
    push_chan(7, 0); push_chan(6, 0); push_chan(5, 0); push_chan(4, 0);
    push_chan(3, 0); push_chan(1, 0); push_chan(7, 1); push_head(6, 0);
    run_from_start("down");
    stop_in_second("down_stop", 6);

    // Ping-pong: 0..7, 6..0, 1..
    mode = M_PP; skip_mask = 8'h00;
    for (int ch = 0; ch < N_CHAN; ch++) push_chan(ch, 1'b0);
    for (int ch = N_CHAN - 2; ch >= 0; ch--) push_chan(ch, ch == N_CHAN - 2);
    push_chan(1, 1'b1); push_head(2, 1'b0);
    run_from_start("pingpong");
    stop_in_second("pp_stop", 2);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    push(2, 0, 0, 0); push(2, 0, 0, 0);
    drain_all("start_stop");
    start = 1'b0; stop = 1'b0;

    // Single eligible channel: wrap every advance, blank still inserted
    mode = M_UP; skip_mask = 8'hFE;
    push_chan(0, 0); push_chan(0, 1); push_head(0, 1);
    run_from_start("single");
    stop_in_second("single_stop", 0);

    // Hold entered during dwell on idx 1; stop exits on the next cycle
    skip_mask = 8'h00;
    push_chan(0, 0); push(1, 1, 0, 1);
    run_from_start("pre_hold");
    mode = M_HOLD;
    push(1, 1, 0, 1); push(1, 1, 0, 1); push(1, 1, 0, 1);
    push(1, 0, 0, 1);
    for (int k = 0; k < 10; k++) push(1, 1, 0, 1);
    drain_all("hold");
    stop = 1'b1;
    push(1, 0, 0, 0);
    drain("hold_stop", 1);
    stop = 1'b0;
    push(1, 0, 0, 0);
    drain_all("hold_stop");
    mode = M_UP;

    // Reset in the middle of dwell on idx 4
    for (int ch = 0; ch < 4; ch++) push_chan(ch, 1'b0);
    push(4, 1, 0, 1);
    run_from_start("pre_rst");
    rst = 1'b1;
    push(0, 0, 0, 0);
    drain("mid_rst", 1);
    rst = 1'b0;
    push(0, 0, 0, 0); push(0, 0, 0, 0);
    drain_all("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
